snow64_mem_access_arbiter: RTL and testbench

- Shares the single external memory data-access port between two requesters: instruction fetch (port 0) and LAR-file load/store (port 1).
- Uses round-robin arbitration and serialises one transaction at a time.
- Holds external request signals stable until the memory returns valid.
- A watchdog flags hung transactions.
- Sits between the CPU core requesters and the core's ext_dat_acc_mem output/input port pair.

---
 rtl/snow64_mem_access_arbiter.sv | 139 +++++++++++++
 tb/tb_snow64_mem_access_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/snow64_mem_access_arbiter.sv
// Round-robin arbiter sharing the external data-access memory port between
// instruction fetch (port 0) and LAR load/store (port 1), one transaction at a time.
module snow64_mem_access_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            rq_req,
    input  logic [1:0]            rq_acc_type,
    input  logic [ADDR_WIDTH-1:0] rq_addr_0,
    input  logic [ADDR_WIDTH-1:0] rq_addr_1,
    input  logic [DATA_WIDTH-1:0] rq_data_0,
    input  logic [DATA_WIDTH-1:0] rq_data_1,
    output logic [1:0]            rq_valid,
    output logic [1:0]            rq_err,
    output logic [DATA_WIDTH-1:0] rq_rdata,
    output logic                  mem_req,
    output logic                  mem_acc_type,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  winner_q, winner_d;
    logic                  prio_q, prio_d;
    logic [CNT_WIDTH-1:0]  wd_q, wd_d;
    logic                  grant;

    logic [1:0]            rq_valid_d, rq_err_d;
    logic [DATA_WIDTH-1:0] rq_rdata_d;
    logic                  mem_req_d, mem_acc_type_d, busy_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_d;

    // State and every output register; reset drops mem_req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            winner_q     <= 1'b0;
            prio_q       <= 1'b0;
            wd_q         <= '0;
            rq_valid     <= '0;
            rq_err       <= '0;
            rq_rdata     <= '0;
            mem_req      <= 1'b0;
            mem_acc_type <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            prio_q       <= prio_d;
            wd_q         <= wd_d;
            rq_valid     <= rq_valid_d;
            rq_err       <= rq_err_d;
            rq_rdata     <= rq_rdata_d;
            mem_req      <= mem_req_d;
            mem_acc_type <= mem_acc_type_d;
            mem_addr     <= mem_addr_d;
            mem_wdata    <= mem_wdata_d;
            busy         <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        prio_d         = prio_q;
        wd_d           = wd_q;
        grant          = 1'b0;
        rq_valid_d     = '0;
        rq_err_d       = '0;
        rq_rdata_d     = rq_rdata;
        mem_req_d      = mem_req;
        mem_acc_type_d = mem_acc_type;
        mem_addr_d     = mem_addr;
        mem_wdata_d    = mem_wdata;

        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (rq_req != 2'b00) begin
                    // Tie goes to rr_prio; a lone request wins outright.
                    grant          = (rq_req == 2'b11) ? prio_q : rq_req[1];
                    winner_d       = grant;
                    prio_d         = ~grant;
                    mem_acc_type_d = rq_acc_type[grant];
                    mem_addr_d     = grant ? rq_addr_1 : rq_addr_0;
                    mem_wdata_d    = grant ? rq_data_1 : rq_data_0;
                    mem_req_d      = 1'b1;
                    wd_d           = '0;
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (mem_valid) begin
                    rq_rdata_d           = mem_rdata;
                    rq_valid_d[winner_q] = 1'b1;
                    mem_req_d            = 1'b0;
                    state_d              = DONE;
                end else if (wd_q == WD_LAST) begin
                    rq_rdata_d           = '0;
                    rq_valid_d[winner_q] = 1'b1;
                    rq_err_d[winner_q]   = 1'b1;
                    mem_req_d            = 1'b0;
                    state_d              = DONE;
                end else begin
                    wd_d = wd_q + CNT_WIDTH'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_snow64_mem_access_arbiter.sv
// Directed self-checking bench for snow64_mem_access_arbiter (TIMEOUT_CYCLES=8).
module tb_snow64_mem_access_arbiter;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 256;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    rq_req = '0;
    logic [1:0]    rq_acc_type = '0;
    logic [AW-1:0] rq_addr_0 = '0;
    logic [AW-1:0] rq_addr_1 = '0;
    logic [DW-1:0] rq_data_0 = '0;
    logic [DW-1:0] rq_data_1 = '0;
    logic [1:0]    rq_valid;
    logic [1:0]    rq_err;
    logic [DW-1:0] rq_rdata;
    logic          mem_req;
    logic          mem_acc_type;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_valid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    int checks = 0;
    int errors = 0;

    snow64_mem_access_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rq_req(rq_req), .rq_acc_type(rq_acc_type),
        .rq_addr_0(rq_addr_0), .rq_addr_1(rq_addr_1),
        .rq_data_0(rq_data_0), .rq_data_1(rq_data_1),
        .rq_valid(rq_valid), .rq_err(rq_err), .rq_rdata(rq_rdata),
        .mem_req(mem_req), .mem_acc_type(mem_acc_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, DW'(mem_req), DW'(1'b1));
    endtask

    // One-cycle memory completion; returns sampled in the DONE cycle.
    task automatic pulse_valid(input logic [DW-1:0] d);
        mem_valid = 1'b1;
        mem_rdata = d;
        tick();
        mem_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] pat_a5;
        int n;
        pat_a5 = {32{8'hA5}};

        do_reset();
        check("rst_mem_req", DW'(mem_req), DW'(1'b0));
        check("rst_rq_valid", DW'(rq_valid), DW'(2'b00));
        check("rst_busy", DW'(busy), DW'(1'b0));
        check("rst_mem_addr", DW'(mem_addr), DW'(0));

        // Single read on port 0, memory answers 3 cycles after mem_req.
        rq_addr_0 = 64'h1000;
        rq_acc_type = 2'b00;
        rq_req = 2'b01;
        tick();
        check("rd_grant_latency", DW'(mem_req), DW'(1'b1));
        check("rd_mem_addr", DW'(mem_addr), DW'(64'h1000));
        check("rd_acc_type", DW'(mem_acc_type), DW'(1'b0));
        check("rd_busy", DW'(busy), DW'(1'b1));
        repeat (2) tick();
        check("rd_hold_req", DW'(mem_req), DW'(1'b1));
        pulse_valid(pat_a5);
        check("rd_valid", DW'(rq_valid), DW'(2'b01));
        check("rd_rdata", rq_rdata, pat_a5);
        check("rd_mem_req_drop", DW'(mem_req), DW'(1'b0));
        rq_req = 2'b00;
        tick();
        check("rd_valid_one_cycle", DW'(rq_valid), DW'(2'b00));
        check("rd_busy_low", DW'(busy), DW'(1'b0));

        // Round robin from a fresh reset with both ports requesting.
        do_reset();
        rq_addr_0 = 64'h10;
        rq_addr_1 = 64'h20;
        rq_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_mem_req("rr_mem_req");
            check("rr_mem_addr", DW'(mem_addr), (i % 2 == 1) ? DW'(64'h20) : DW'(64'h10));
            pulse_valid(DW'(i));
            check("rr_valid", DW'(rq_valid), (i % 2 == 1) ? DW'(2'b10) : DW'(2'b01));
            if (i == 3) rq_req = 2'b00;
            tick();
            check("rr_valid_clear", DW'(rq_valid), DW'(2'b00));
        end
        tick();
        check("rr_idle_after", DW'(busy), DW'(1'b0));

        // Port 1 write: data latched at grant despite input change.
        rq_addr_1 = 64'h40;
        rq_data_1 = DW'(16'h1234);
        rq_acc_type = 2'b10;
        rq_req = 2'b10;
        wait_mem_req("wr_mem_req");
        rq_data_1 = DW'(16'hFFFF);
        rq_addr_1 = 64'h99;
        check("wr_acc_type", DW'(mem_acc_type), DW'(1'b1));
        repeat (2) tick();
        check("wr_wdata_stable", mem_wdata, DW'(16'h1234));
        check("wr_addr_stable", DW'(mem_addr), DW'(64'h40));
        pulse_valid(DW'(16'h5555));
        check("wr_valid", DW'(rq_valid), DW'(2'b10));
        check("wr_err", DW'(rq_err), DW'(2'b00));
        rq_req = 2'b00;
        tick();

        // Timeout: mem_valid never comes.
        rq_acc_type = 2'b00;
        rq_addr_0 = 64'h2000;
        rq_req = 2'b01;
        wait_mem_req("to_mem_req");
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check("to_req_cycles", DW'(n), DW'(TO));
        check("to_valid", DW'(rq_valid), DW'(2'b01));
        check("to_err", DW'(rq_err), DW'(2'b01));
        check("to_rdata_zero", rq_rdata, DW'(0));
        rq_req = 2'b00;
        tick();
        check("to_err_clear", DW'(rq_err), DW'(2'b00));
        check("to_idle", DW'(busy), DW'(1'b0));

        // Reset mid-WAIT aborts without completion.
        rq_req = 2'b01;
        wait_mem_req("rst_wait_req");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_req", DW'(mem_req), DW'(1'b0));
        check("rst_async_busy", DW'(busy), DW'(1'b0));
        rq_req = 2'b00;
        repeat (2) begin
            tick();
            check("rst_no_valid", DW'(rq_valid), DW'(2'b00));
        end
        rst_n = 1'b1;
        tick();
        rq_addr_0 = 64'h10;
        rq_addr_1 = 64'h20;
        rq_req = 2'b11;
        tick();
        check("rst_prio_port0", DW'(mem_addr), DW'(64'h10));
        pulse_valid(pat_a5);
        check("rst_prio_valid", DW'(rq_valid), DW'(2'b01));
        rq_req = 2'b00;
        tick();

        // mem_valid on the very timeout cycle wins: no error.
        rq_req = 2'b10;
        wait_mem_req("co_mem_req");
        repeat (TO - 1) tick();
        check("co_req_held", DW'(mem_req), DW'(1'b1));
        pulse_valid(DW'(32'hCAFE));
        check("co_valid", DW'(rq_valid), DW'(2'b10));
        check("co_err", DW'(rq_err), DW'(2'b00));
        check("co_rdata", rq_rdata, DW'(32'hCAFE));
        rq_req = 2'b00;
        tick();

        // Stray mem_valid while idle.
        tick();
        mem_valid = 1'b1;
        mem_rdata = '1;
        tick();
        mem_valid = 1'b0;
        check("stray_valid", DW'(rq_valid), DW'(2'b00));
        check("stray_busy", DW'(busy), DW'(1'b0));
        tick();
        check("stray_req", DW'(mem_req), DW'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
